pipelined_carry_skip_adder: RTL and testbench



---
 rtl/pipelined_carry_skip_adder_if.sv | 37 +++
 rtl/pipelined_carry_skip_adder.sv | 146 ++++++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_carry_skip_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_carry_skip_adder_if
//  Description : Operand/result handshake bundle for the pipelined
//                carry-skip adder. The master side offers operands and
//                consumes results; the slave side is the adder.
//  Signals     : in_valid/in_ready  - operand handshake
//                a, b, cin          - operands and carry in
//                out_valid/out_ready- result handshake
//                sum, cout, ovf     - result, carry out, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_carry_skip_adder_if #(
    parameter int N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_carry_skip_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_carry_skip_adder
//  Description : N-bit adder built from BLOCK_SIZE-bit ripple blocks with
//                carry-skip muxes, registered after every BLOCKS_PER_STAGE
//                blocks. Valid/ready handshake with a global stall.
//  Ports       : clk    - rising-edge clock
//                rst_n  - synchronous active-low reset
//                bus    - slave side of pipelined_carry_skip_adder_if
//                         (operands in, sum/cout/ovf out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_carry_skip_adder #(
    parameter int N                = 16,
    parameter int BLOCK_SIZE       = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    pipelined_carry_skip_adder_if.slave    bus
);

    localparam int NBLK   = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int STAGES = (NBLK + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
    // Operands are widened to a whole number of stages. Padding bits are
    // a=1, b=0: pure propagate, so the carry passes through them untouched
    // and a partial or empty trailing block never alters the skip decision.
    localparam int NPAD   = STAGES * BLOCKS_PER_STAGE * BLOCK_SIZE;

    // Stage boundary signals: index 0 is the input side, index k+1 is the
    // register bank of stage k.
    logic [N-1:0] st_a  [STAGES];
    logic [N-1:0] st_b  [STAGES];
    logic [N-1:0] st_s  [STAGES+1];
    logic         st_c  [STAGES+1];
    logic [1:0]   st_sg [STAGES+1];   // {a[N-1], b[N-1]} for the overflow flag
    logic         st_v  [STAGES+1];

    logic w_advance;

    assign w_advance    = !st_v[STAGES] || bus.out_ready;
    assign bus.in_ready = w_advance;

    assign st_a[0]  = bus.a;
    assign st_b[0]  = bus.b;
    assign st_s[0]  = '0;
    assign st_c[0]  = bus.cin;
    assign st_sg[0] = {bus.a[N-1], bus.b[N-1]};
    assign st_v[0]  = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SBASE = k * BLOCKS_PER_STAGE * BLOCK_SIZE;

        logic [NPAD-1:0] w_ap;
        logic [NPAD-1:0] w_bp;
        logic            w_c;
        logic            w_rc;
        logic            w_allp;
        logic            w_p;
        logic [N-1:0]    sum_d;
        logic            carry_d;

        logic [N-1:0]    sum_q;
        logic            carry_q;
        logic [1:0]      sg_q;
        logic            valid_q;

        always_comb begin
            w_ap          = '1;
            w_ap[N-1:0]   = st_a[k];
            w_bp          = '0;
            w_bp[N-1:0]   = st_b[k];
            sum_d         = st_s[k];
            w_c           = st_c[k];
            w_rc          = 1'b0;
            w_allp        = 1'b1;
            w_p           = 1'b0;
            for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
                w_rc   = w_c;
                w_allp = 1'b1;
                for (int t = 0; t < BLOCK_SIZE; t++) begin
                    w_p = w_ap[SBASE + j*BLOCK_SIZE + t] ^ w_bp[SBASE + j*BLOCK_SIZE + t];
                    if (SBASE + j*BLOCK_SIZE + t < N) begin
                        sum_d[SBASE + j*BLOCK_SIZE + t] = w_p ^ w_rc;
                    end
                    w_rc   = (w_ap[SBASE + j*BLOCK_SIZE + t] & w_bp[SBASE + j*BLOCK_SIZE + t])
                           | (w_p & w_rc);
                    w_allp = w_allp & w_p;
                end
                // Skip mux: an all-propagate block forwards its carry-in.
                w_c = w_allp ? w_c : w_rc;
            end
            carry_d = w_c;
        end

        // Data registers only load real operands; bubbles leave them alone,
        // which also keeps the outputs at zero after reset until a result.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
                sg_q    <= 2'b00;
            end else if (w_advance) begin
                valid_q <= st_v[k];
                if (st_v[k]) begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    sg_q    <= st_sg[k];
                end
            end
        end

        assign st_s[k+1]  = sum_q;
        assign st_c[k+1]  = carry_q;
        assign st_sg[k+1] = sg_q;
        assign st_v[k+1]  = valid_q;

        // Operands are needed only by stages still to come.
        if (k < STAGES - 1) begin : g_opnd
            logic [N-1:0] a_q;
            logic [N-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (w_advance && st_v[k]) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
        end
    end

    assign bus.out_valid = st_v[STAGES];
    assign bus.sum       = st_s[STAGES];
    assign bus.cout      = st_c[STAGES];
    assign bus.ovf       = (st_sg[STAGES][1] == st_sg[STAGES][0])
                        && (st_s[STAGES][N-1] != st_sg[STAGES][1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_skip_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_carry_skip_adder
//  Description : Self-checking bench for pipelined_carry_skip_adder with
//                three configurations: 16/4/2, 8/4/1 and 1/4/1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_carry_skip_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_carry_skip_adder_if #(.N(16)) if16 ();
    pipelined_carry_skip_adder_if #(.N(8))  if8  ();
    pipelined_carry_skip_adder_if #(.N(1))  if1  ();

    pipelined_carry_skip_adder #(.N(16), .BLOCK_SIZE(4), .BLOCKS_PER_STAGE(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16));
    pipelined_carry_skip_adder #(.N(8),  .BLOCK_SIZE(4), .BLOCKS_PER_STAGE(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8));
    pipelined_carry_skip_adder #(.N(1),  .BLOCK_SIZE(4), .BLOCKS_PER_STAGE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  q8  [$];
    logic [17:0] q16 [$];
    logic [2:0]  q1  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference results packed as {cout, sum, ovf}, from plain arithmetic.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'b0, c};
        return {t[8], t[7:0], (a[7] == b[7]) && (t[7] != a[7])};
    endfunction

    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b} + {16'b0, c};
        return {t[16], t[15:0], (a[15] == b[15]) && (t[15] != a[15])};
    endfunction

    function automatic logic [2:0] ref1(input logic a, input logic b, input logic c);
        logic [1:0] t;
        t = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return {t[1], t[0], (a == b) && (t[0] != a)};
    endfunction

    // Each step: drive at posedge+1, settle, score both handshakes for the
    // coming edge, then advance to the next posedge+1.
    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic ordy, output logic acc);
        logic [9:0] e;
        if8.in_valid = v; if8.a = a; if8.b = b; if8.cin = c; if8.out_ready = ordy;
        #1;
        acc = v && if8.in_ready;
        if (if8.out_valid && ordy) begin
            if (q8.size() == 0) check("d8_spurious_valid", if8.out_valid, 0);
            else begin
                e = q8.pop_front();
                check("d8_result", {if8.cout, if8.sum, if8.ovf}, e);
            end
        end
        if (acc) q8.push_back(ref8(a, b, c));
        @(posedge clk); #1;
    endtask

    task automatic step16(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic ordy, output logic acc);
        logic [17:0] e;
        if16.in_valid = v; if16.a = a; if16.b = b; if16.cin = c; if16.out_ready = ordy;
        #1;
        acc = v && if16.in_ready;
        if (if16.out_valid && ordy) begin
            if (q16.size() == 0) check("r16_spurious_valid", if16.out_valid, 0);
            else begin
                e = q16.pop_front();
                check("r16_result", {if16.cout, if16.sum, if16.ovf}, e);
            end
        end
        if (acc) q16.push_back(ref16(a, b, c));
        @(posedge clk); #1;
    endtask

    task automatic step1(input logic v, input logic a, input logic b,
                         input logic c, input logic ordy, output logic acc);
        logic [2:0] e;
        if1.in_valid = v; if1.a = a; if1.b = b; if1.cin = c; if1.out_ready = ordy;
        #1;
        acc = v && if1.in_ready;
        if (if1.out_valid && ordy) begin
            if (q1.size() == 0) check("n1_spurious_valid", if1.out_valid, 0);
            else begin
                e = q1.pop_front();
                check("n1_result", {if1.cout, if1.sum, if1.ovf}, e);
            end
        end
        if (acc) q1.push_back(ref1(a, b, c));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [7:0]  t2a [3];
        logic [7:0]  t2b [3];
        logic        t2c [3];
        logic [9:0]  t2e [3];
        logic [7:0]  t3a [3];
        logic [7:0]  t3b [3];
        logic        t3c [3];
        int          idx;
        int          acc_n;
        int          cyc;
        logic [15:0] ra, rb;
        logic [3:0]  cc;

        t2a = '{8'h7F, 8'h80, 8'h0F};
        t2b = '{8'h01, 8'h80, 8'hF0};
        t2c = '{1'b0, 1'b0, 1'b1};
        t2e = '{10'b0_10000000_1, 10'b1_00000000_1, 10'b1_00000000_0};
        t3a = '{8'h12, 8'hF0, 8'h55};
        t3b = '{8'h34, 8'hF0, 8'hAA};
        t3c = '{1'b0, 1'b1, 1'b1};

        if16.in_valid = 0; if16.a = 0; if16.b = 0; if16.cin = 0; if16.out_ready = 1;
        if8.in_valid  = 0; if8.a  = 0; if8.b  = 0; if8.cin  = 0; if8.out_ready  = 0;
        if1.in_valid  = 0; if1.a  = 0; if1.b  = 0; if1.cin  = 0; if1.out_ready  = 1;

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst8",  {if8.out_valid,  if8.cout,  if8.ovf,  if8.sum},  0);
        check("rst16", {if16.out_valid, if16.cout, if16.ovf, if16.sum}, 0);
        check("rst1",  {if1.out_valid,  if1.cout,  if1.ovf,  if1.sum},  0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst8_in_ready",  if8.in_ready,  1);
        check("rst16_in_ready", if16.in_ready, 1);

        // ---- single full-propagate operand, latency 2 ----
        step8(1, 8'hFF, 8'h01, 0, 1, acc);
        check("t1_accept", acc, 1);
        check("t1_early_valid", if8.out_valid, 0);
        step8(0, 8'h00, 8'h00, 0, 1, acc);
        check("t1_valid", if8.out_valid, 1);
        check("t1_result", {if8.cout, if8.sum, if8.ovf}, 10'b1_00000000_0);
        step8(0, 8'h00, 8'h00, 0, 1, acc);
        check("t1_no_dup", if8.out_valid, 0);

        // ---- back-to-back ----
        for (int i = 0; i < 5; i++) begin
            step8(i < 3, (i < 3) ? t2a[i] : 8'h00, (i < 3) ? t2b[i] : 8'h00,
                  (i < 3) ? t2c[i] : 1'b0, 1, acc);
            if (i >= 1 && i <= 3) begin
                check("t2_valid", if8.out_valid, 1);
                check("t2_seq", {if8.cout, if8.sum, if8.ovf}, t2e[i-1]);
            end else begin
                check("t2_idle", if8.out_valid, 0);
            end
        end
        check("t2_q_empty", q8.size(), 0);

        // ---- backpressure ----
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step8(idx < 3, (idx < 3) ? t3a[idx] : 8'h00, (idx < 3) ? t3b[idx] : 8'h00,
                  (idx < 3) ? t3c[idx] : 1'b0, 0, acc);
            if (acc) idx++;
            if (if8.out_valid) begin
                check("t3_in_ready_low", if8.in_ready, 0);
                check("t3_hold", {if8.cout, if8.sum, if8.ovf}, ref8(t3a[0], t3b[0], t3c[0]));
            end
        end
        check("t3_accepted_while_stalled", idx, 2);
        for (int i = 0; i < 8; i++) begin
            step8(idx < 3, (idx < 3) ? t3a[idx] : 8'h00, (idx < 3) ? t3b[idx] : 8'h00,
                  (idx < 3) ? t3c[idx] : 1'b0, 1, acc);
            if (acc) idx++;
        end
        check("t3_accepted", idx, 3);
        check("t3_q_empty", q8.size(), 0);

        // ---- reset mid-flight ----
        step8(1, 8'h21, 8'h43, 0, 1, acc);
        step8(1, 8'hA5, 8'h5A, 1, 1, acc);
        check("t4_full_pipe", if8.out_valid, 1);
        if8.in_valid = 0; if8.out_ready = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t4_valid_cleared", if8.out_valid, 0);
        check("t4_sum_cleared", if8.sum, 0);
        rst_n = 1'b1;
        q8.delete();
        @(posedge clk); #1;
        check("t4_in_ready", if8.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step8(0, 8'h00, 8'h00, 0, 1, acc);
            check("t4_no_stale", if8.out_valid, 0);
        end

        // ---- randomized default configuration ----
        acc_n = 0;
        cyc   = 0;
        while (acc_n < 1000 && cyc < 20000) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ~ra : 16'($urandom);
            step16($urandom_range(0, 3) != 0, ra, rb, 1'($urandom),
                   $urandom_range(0, 3) != 0, acc);
            if (acc) acc_n++;
            cyc++;
        end
        check("r16_count", acc_n, 1000);
        for (int i = 0; i < 8; i++) step16(0, 16'h0, 16'h0, 0, 1, acc);
        check("r16_drain", q16.size(), 0);

        // ---- N=1, all operand combinations, latency 1 ----
        for (int c = 0; c < 10; c++) begin
            check("n1_latency", if1.out_valid, (c >= 1 && c <= 8));
            cc = 4'(c);
            step1(c < 8, cc[2], cc[1], cc[0], 1, acc);
        end
        check("n1_q_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
